text_console: RTL and testbench

Parametrised memory-mapped text console engine that replaces direct CPU writes into the VGA character buffer. It accepts a character/command stream from the CPU's MMIO store path and owns the ROWS×COLS character RAM. It maintains the cursor, handles newline/carriage-return/backspace, and performs hardware scroll via a rotating top-row pointer with automatic clearing of the new bottom row. A second read port with row-rotation applied feeds the VGA glyph pipeline, and a blink generator drives the cursor overlay.

---
 rtl/text_console_if.sv | 21 ++
 rtl/text_console.sv | 253 +++++++++++++++++++++++++
 tb/tb_text_console.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_if.sv
// Command bus carrying the CPU's character/command stream into the text console.
interface text_console_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/text_console.sv
// Text console engine: owns the ROWS x COLS character RAM, tracks the cursor,
// scrolls by rotating the top-row pointer and serves row-rotated reads to the
// VGA glyph pipeline, plus a cursor blink generator.
module text_console #(
  parameter int COLS      = 70,
  parameter int ROWS      = 30,
  parameter int BLINK_DIV = 12_500_000,
  localparam int CB = $clog2(COLS),
  localparam int RB = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  text_console_if.slave cmd,
  input  logic [RB-1:0] rd_row,
  input  logic [CB-1:0] rd_col,
  output logic [7:0]    rd_char,
  output logic [RB-1:0] cur_row,
  output logic [CB-1:0] cur_col,
  output logic          cursor_blink,
  output logic [RB-1:0] top_row
);

  localparam int AW    = RB + CB;
  localparam int CELLS = ROWS * COLS;
  // The RAM spans the full address space so the cell index width matches exactly.
  localparam int DEPTH = 1 << AW;
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [7:0]    SPACE     = 8'h20;
  localparam logic [RB-1:0] ROW_MAX   = RB'(ROWS - 1);
  localparam logic [CB-1:0] COL_MAX   = CB'(COLS - 1);
  localparam logic [AW-1:0] CELL_MAX  = AW'(CELLS - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCRL
  } state_t;

  typedef enum logic [1:0] {
    OP_PUTC   = 2'd0,
    OP_SETCUR = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_NOP    = 2'd3
  } op_t;

  state_t        state, state_next;
  logic [RB-1:0] cur_row_next;
  logic [CB-1:0] cur_col_next;
  logic [RB-1:0] top_row_next;
  logic [AW-1:0] fill_idx, fill_idx_next;
  logic [RB-1:0] scrl_row, scrl_row_next;
  logic [CB-1:0] scrl_col, scrl_col_next;
  logic [BW-1:0] blink_cnt;

  logic          accept;
  logic          do_newline;
  logic [7:0]    put_char;
  logic [RB-1:0] set_row;
  logic [CB-1:0] set_col;
  logic [RB-1:0] cur_phys_row;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;

  logic [7:0] char_ram [DEPTH];

  logic cmd_data_unused;

  // Maps a logical screen row onto its physical RAM row under the current rotation.
  function automatic logic [RB-1:0] phys_row(input logic [RB-1:0] row,
                                             input logic [RB-1:0] top);
    logic [RB:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= (RB+1)'(ROWS)) begin
      sum = sum - (RB+1)'(ROWS);
    end
    return sum[RB-1:0];
  endfunction

  // Linear cell index row*COLS+col, kept in RB+CB bits.
  function automatic logic [AW-1:0] cell_addr(input logic [RB-1:0] row,
                                              input logic [CB-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  assign cmd.cmd_ready   = (state == IDLE);
  assign accept          = cmd.cmd_valid && (state == IDLE);
  assign put_char        = cmd.cmd_data[7:0];
  assign set_row         = cmd.cmd_data[RB+CB-1:CB];
  assign set_col         = cmd.cmd_data[CB-1:0];
  assign cur_phys_row    = phys_row(cur_row, top_row);
  assign rd_addr         = cell_addr(phys_row(rd_row, top_row), rd_col);
  assign cmd_data_unused = ^cmd.cmd_data;

  // Command decode, cursor movement, scroll/clear sequencing and the single RAM write port.
  always_comb begin
    state_next    = state;
    cur_row_next  = cur_row;
    cur_col_next  = cur_col;
    top_row_next  = top_row;
    fill_idx_next = fill_idx;
    scrl_row_next = scrl_row;
    scrl_col_next = scrl_col;
    do_newline    = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = SPACE;

    case (state)
      IDLE: begin
        if (accept) begin
          case (op_t'(cmd.cmd_op))
            OP_PUTC: begin
              if ((put_char >= 8'h20) && (put_char <= 8'h7E)) begin
                wr_en   = 1'b1;
                wr_addr = cell_addr(cur_phys_row, cur_col);
                wr_data = put_char;
                if (cur_col == COL_MAX) begin
                  cur_col_next = '0;
                  do_newline   = 1'b1;
                end else begin
                  cur_col_next = cur_col + CB'(1);
                end
              end else if (put_char == 8'h0A) begin
                do_newline = 1'b1;
              end else if (put_char == 8'h0D) begin
                cur_col_next = '0;
              end else if (put_char == 8'h08) begin
                if (cur_col != '0) begin
                  cur_col_next = cur_col - CB'(1);
                  wr_en        = 1'b1;
                  wr_addr      = cell_addr(cur_phys_row, cur_col - CB'(1));
                  wr_data      = SPACE;
                end
              end
            end
            OP_SETCUR: begin
              cur_row_next = (set_row > ROW_MAX) ? ROW_MAX : set_row;
              cur_col_next = (set_col > COL_MAX) ? COL_MAX : set_col;
            end
            OP_CLEAR: begin
              state_next    = CLEAR;
              fill_idx_next = '0;
              cur_row_next  = '0;
              cur_col_next  = '0;
              top_row_next  = '0;
            end
            default: begin
            end
          endcase

          if (do_newline) begin
            if (cur_row != ROW_MAX) begin
              cur_row_next = cur_row + RB'(1);
            end else begin
              // The old top row becomes the new bottom row and is blanked in SCRL.
              top_row_next  = (top_row == ROW_MAX) ? '0 : top_row + RB'(1);
              scrl_row_next = top_row;
              scrl_col_next = '0;
              state_next    = SCRL;
            end
          end
        end
      end

      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = fill_idx;
        wr_data = SPACE;
        if (fill_idx == CELL_MAX) begin
          state_next = IDLE;
        end else begin
          fill_idx_next = fill_idx + AW'(1);
        end
      end

      SCRL: begin
        wr_en   = 1'b1;
        wr_addr = cell_addr(scrl_row, scrl_col);
        wr_data = SPACE;
        if (scrl_col == COL_MAX) begin
          state_next = IDLE;
        end else begin
          scrl_col_next = scrl_col + CB'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Engine state register; reset restarts a full clear of the screen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      fill_idx <= '0;
      cur_row  <= '0;
      cur_col  <= '0;
      top_row  <= '0;
      scrl_row <= '0;
      scrl_col <= '0;
    end else begin
      state    <= state_next;
      fill_idx <= fill_idx_next;
      cur_row  <= cur_row_next;
      cur_col  <= cur_col_next;
      top_row  <= top_row_next;
      scrl_row <= scrl_row_next;
      scrl_col <= scrl_col_next;
    end
  end

  // Cursor blink: free-running half-period counter, held solid by any accepted command.
  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_blink <= 1'b1;
      blink_cnt    <= '0;
    end else if (accept) begin
      cursor_blink <= 1'b1;
      blink_cnt    <= '0;
    end else if (blink_cnt == BLINK_MAX) begin
      cursor_blink <= ~cursor_blink;
      blink_cnt    <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Engine write port into the character RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      char_ram[wr_addr] <= wr_data;
    end
  end

  // VGA read port: registered, read-first, blanks for out-of-range coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_char <= SPACE;
    end else if ((rd_row > ROW_MAX) || (rd_col > COL_MAX)) begin
      rd_char <= SPACE;
    end else begin
      rd_char <= char_ram[rd_addr];
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Directed self-checking bench for text_console: reset clear, typing,
// backspace, wrap and scroll, cursor clamping, full clear and cursor blink.
module tb_text_console;

  localparam int COLS      = 70;
  localparam int ROWS      = 30;
  localparam int BLINK_DIV = 4;
  localparam int CB        = $clog2(COLS);
  localparam int RB        = $clog2(ROWS);

  localparam logic [1:0] OP_PUTC   = 2'd0;
  localparam logic [1:0] OP_SETCUR = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;
  localparam logic [1:0] OP_NOP    = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [RB-1:0] rd_row;
  logic [CB-1:0] rd_col;
  logic [7:0]    rd_char;
  logic [RB-1:0] cur_row;
  logic [CB-1:0] cur_col;
  logic          cursor_blink;
  logic [RB-1:0] top_row;

  int n_checks = 0;
  int n_fail   = 0;

  text_console_if bus ();

  text_console #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (bus),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rd_char      (rd_char),
    .cur_row      (cur_row),
    .cur_col      (cur_col),
    .cursor_blink (cursor_blink),
    .top_row      (top_row)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [15:0] data,
                                input int budget);
    wait_ready($sformatf("ready before op%0d data 0x%0h", op, data), budget);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = 16'h0000;
  endtask

  task automatic count_ready_low(input int limit, output int n);
    n = 0;
    while (!bus.cmd_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] v);
    rd_row = RB'(r);
    rd_col = CB'(c);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic count_nonspace_row(input int r, output int bad);
    logic [7:0] v;
    bad = 0;
    for (int c = 0; c < COLS; c++) begin
      read_cell(r, c, v);
      if (v !== 8'h20) bad++;
    end
  endtask

  task automatic count_nonspace_all(output int bad);
    int row_bad;
    bad = 0;
    for (int r = 0; r < ROWS; r++) begin
      count_nonspace_row(r, row_bad);
      bad += row_bad;
    end
  endtask

  task automatic check_cursor(input string tag, input int r, input int c);
    check_output({tag, " cur_row"}, 32'(cur_row), r);
    check_output({tag, " cur_col"}, 32'(cur_col), c);
  endtask

  // Bounds the whole run in case the engine stalls forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [7:0] v;
    int n;
    int bad;

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = 16'h0000;
    rd_row        = '0;
    rd_col        = '0;

    $display("[TB] reset and power-up clear");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("ready in reset", 32'(bus.cmd_ready), 32'd0);
    check_output("rd_char in reset", 32'(rd_char), 32'h20);
    check_output("blink in reset", 32'(cursor_blink), 32'd1);
    reset = 1'b0;
    check_cursor("after reset", 0, 0);
    check_output("top_row after reset", 32'(top_row), 32'd0);
    count_ready_low(5000, n);
    check_output("ready low after reset", n, 32'd2100);
    count_nonspace_all(bad);
    check_output("nonspace cells after reset", bad, 32'd0);

    $display("[TB] typing, backspace and read-first");
    apply_stimulus(OP_PUTC, 16'h0048, 0);
    apply_stimulus(OP_PUTC, 16'h0069, 0);
    check_cursor("after Hi", 0, 2);
    read_cell(0, 1, v);
    check_output("cell 0,1 after Hi", 32'(v), 32'h69);
    apply_stimulus(OP_PUTC, 16'h0008, 0);
    check_cursor("after backspace", 0, 1);
    read_cell(0, 1, v);
    check_output("cell 0,1 after backspace", 32'(v), 32'h20);
    read_cell(0, 0, v);
    check_output("cell 0,0", 32'(v), 32'h48);
    rd_row = 5'd0;
    rd_col = 7'd1;
    apply_stimulus(OP_PUTC, 16'h0041, 0);
    check_output("read-first old value", 32'(rd_char), 32'h20);
    @(negedge clk);
    check_output("read after write", 32'(rd_char), 32'h41);
    check_cursor("after A", 0, 2);
    apply_stimulus(OP_PUTC, 16'h000D, 0);
    check_cursor("after CR", 0, 0);
    apply_stimulus(OP_PUTC, 16'h000A, 0);
    check_cursor("after LF", 1, 0);

    $display("[TB] line wrap without scroll");
    apply_stimulus(OP_SETCUR, 16'd453, 0);
    check_cursor("setcur 3,69", 3, 69);
    apply_stimulus(OP_PUTC, 16'h0045, 0);
    check_cursor("after wrap", 4, 0);
    check_output("top_row after wrap", 32'(top_row), 32'd0);
    apply_stimulus(OP_NOP, 16'h0000, 0);
    read_cell(3, 69, v);
    check_output("cell 3,69", 32'(v), 32'h45);

    $display("[TB] scroll from bottom-right corner");
    apply_stimulus(OP_SETCUR, 16'h0EC5, 0);
    check_cursor("setcur 29,69", 29, 69);
    apply_stimulus(OP_PUTC, 16'h005A, 0);
    check_output("top_row after scroll", 32'(top_row), 32'd1);
    check_cursor("after scroll", 29, 0);
    check_output("ready after scroll", 32'(bus.cmd_ready), 32'd0);
    count_ready_low(500, n);
    check_output("ready low during scroll", n, 32'd70);
    count_nonspace_row(29, bad);
    check_output("nonspace in new bottom row", bad, 32'd0);
    read_cell(28, 69, v);
    check_output("cell 28,69 after scroll", 32'(v), 32'h5A);
    read_cell(2, 69, v);
    check_output("cell 2,69 rotated", 32'(v), 32'h45);
    apply_stimulus(OP_PUTC, 16'h0008, 0);
    check_cursor("backspace at col 0", 29, 0);

    $display("[TB] cursor clamp, ignored codes, out-of-range read");
    apply_stimulus(OP_SETCUR, 16'hFFFF, 0);
    check_cursor("setcur clamp", 29, 69);
    read_cell(28, 69, v);
    check_output("cell 28,69 after clamp", 32'(v), 32'h5A);
    read_cell(29, 69, v);
    check_output("cell 29,69 after clamp", 32'(v), 32'h20);
    apply_stimulus(OP_PUTC, 16'h0007, 0);
    check_cursor("after bell", 29, 69);
    apply_stimulus(OP_PUTC, 16'h007F, 0);
    check_cursor("after DEL", 29, 69);
    apply_stimulus(OP_SETCUR, 16'd643, 0);
    check_cursor("setcur 5,3", 5, 3);
    apply_stimulus(OP_PUTC, 16'h004D, 0);
    check_cursor("after M", 5, 4);
    read_cell(5, 3, v);
    check_output("cell 5,3", 32'(v), 32'h4D);
    read_cell(4, 73, v);
    check_output("out-of-range col read", 32'(v), 32'h20);

    $display("[TB] clear, 40 newlines, clear again");
    apply_stimulus(OP_CLEAR, 16'h0000, 0);
    check_output("top_row after clear", 32'(top_row), 32'd0);
    check_cursor("after clear", 0, 0);
    count_ready_low(5000, n);
    check_output("ready low during clear", n, 32'd2100);
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(OP_PUTC, 16'h000A, 200);
    end
    count_ready_low(500, n);
    check_output("ready low after last newline", n, 32'd70);
    check_output("top_row after 40 newlines", 32'(top_row), 32'd11);
    check_cursor("after 40 newlines", 29, 0);
    apply_stimulus(OP_PUTC, 16'h0058, 0);
    read_cell(29, 0, v);
    check_output("cell 29,0 after fill", 32'(v), 32'h58);
    apply_stimulus(OP_CLEAR, 16'h0000, 0);
    check_output("top_row after second clear", 32'(top_row), 32'd0);
    check_cursor("after second clear", 0, 0);
    check_output("ready after clear accept", 32'(bus.cmd_ready), 32'd0);
    count_ready_low(5000, n);
    check_output("ready low during second clear", n, 32'd2100);
    count_nonspace_all(bad);
    check_output("nonspace cells after clear", bad, 32'd0);

    $display("[TB] cursor blink");
    apply_stimulus(OP_NOP, 16'h0000, 0);
    check_output("blink after NOP", 32'(cursor_blink), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_output($sformatf("blink free-run %0d", k), 32'(cursor_blink),
                   (k < 4 || k == 8) ? 32'd1 : 32'd0);
    end
    repeat (4) @(negedge clk);
    check_output("blink low before command", 32'(cursor_blink), 32'd0);
    apply_stimulus(OP_PUTC, 16'h000D, 0);
    check_output("blink forced by command", 32'(cursor_blink), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_output($sformatf("blink restart %0d", k), 32'(cursor_blink),
                   (k < 4) ? 32'd1 : 32'd0);
    end

    $display("[TB] reset during clear");
    apply_stimulus(OP_CLEAR, 16'h0000, 0);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("ready in mid-clear reset", 32'(bus.cmd_ready), 32'd0);
    check_output("blink in mid-clear reset", 32'(cursor_blink), 32'd1);
    reset = 1'b0;
    count_ready_low(5000, n);
    check_output("ready low after mid-clear reset", n, 32'd2100);
    check_cursor("after mid-clear reset", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
